// File: rtl/cache_fill_fsm_if.sv
// Handshake bundle between the cache, the fill FSM and main memory.
// The slave modport is the fill FSM's view; master is the cache/memory side.
interface cache_fill_fsm_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_address;
  logic [15:0] cache_data;

  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address,
           write_data_array, write_tag_array, cache_address, cache_data
  );

  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address,
           write_data_array, write_tag_array, cache_address, cache_data
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches one 16-byte block as eight pipelined word reads
// and writes each returned word (tag with the last one) into the cache arrays.
//
// state | meaning
// IDLE  | waiting for a miss; returning memory data is ignored
// FILL  | issuing reads and writing returned words until the last one lands
module cache_fill_fsm #(
  parameter int WORDS       = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [3:0] WORDS_C = 4'(WORDS);
  localparam logic [3:0] LAST_C  = 4'(WORDS - 1);

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  recv_cnt_q, recv_cnt_d;
  logic [15:0] base_q, base_d;

  logic        issue_go;
  logic        recv_go;
  logic        last_go;
  logic [15:0] issue_ofs;
  logic [15:0] recv_ofs;

  assign issue_ofs = {11'd0, issue_cnt_q, 1'b0};
  assign recv_ofs  = {11'd0, recv_cnt_q, 1'b0};

  // A valid with nothing outstanding (recv == issue) is a protocol error and dropped.
  assign issue_go = (state_q == FILL) && (issue_cnt_q < WORDS_C);
  assign recv_go  = (state_q == FILL) && bus.memory_data_valid && (recv_cnt_q < issue_cnt_q);
  assign last_go  = recv_go && (recv_cnt_q == LAST_C);

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    base_d      = base_q;
    case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          base_d      = bus.miss_address & 16'hFFF0;
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 4'd0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (issue_go) issue_cnt_d = issue_cnt_q + 4'd1;
        if (recv_go)  recv_cnt_d  = recv_cnt_q + 4'd1;
        if (last_go)  state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 4'd0;
      base_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
    end
  end

  assign bus.fsm_busy         = (state_q == FILL);
  assign bus.mem_read_en      = issue_go;
  assign bus.memory_address   = issue_go ? (base_q + issue_ofs) : 16'h0000;
  assign bus.write_data_array = recv_go;
  assign bus.write_tag_array  = last_go;
  assign bus.cache_address    = recv_go ? (base_q + recv_ofs) : 16'h0000;
  assign bus.cache_data       = bus.memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a variable-latency memory model feeds a scoreboard
// of expected requests and cache writes pushed when each miss is accepted.
module tb_cache_fill_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_fsm_if bus ();

  cache_fill_fsm #(.WORDS(8), .MEM_LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } wr_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  logic [15:0] exp_req[$];
  wr_t         exp_wr[$];
  ret_t        pend[$];

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  int          lat = 4;
  logic        rst_v = 1'b1;
  logic        miss_v = 1'b0;
  logic [15:0] miss_a = 16'h0;
  logic        stray_v = 1'b0;
  logic        model_fill = 1'b0;
  int          req_k = 0;
  int          wr_in_fill = 0;
  int          fills_done = 0;
  int          tag_seen = 0;
  int          busy_len = 0;
  logic        prev_busy = 1'b0;
  logic        last_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic next_fill;
    wr_t  e;
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_v;
    bus.miss_detected     = miss_v;
    bus.miss_address      = miss_a;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'($urandom);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = pend[0].data;
      void'(pend.pop_front());
    end else if (stray_v) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'hDEAD;
    end
    #1;
    check("cache_data", 32'(bus.cache_data), 32'(bus.memory_data));
    if (rst) begin
      check("rst_busy",    32'(bus.fsm_busy), 0);
      check("rst_rd_en",   32'(bus.mem_read_en), 0);
      check("rst_mem_adr", 32'(bus.memory_address), 0);
      check("rst_wr_data", 32'(bus.write_data_array), 0);
      check("rst_wr_tag",  32'(bus.write_tag_array), 0);
      check("rst_c_adr",   32'(bus.cache_address), 0);
      exp_req.delete();
      exp_wr.delete();
      model_fill = 1'b0;
      busy_len   = 0;
      prev_busy  = 1'b0;
      return;
    end
    next_fill = model_fill;
    check("busy", 32'(bus.fsm_busy), 32'(model_fill));
    if (bus.mem_read_en) begin
      if (exp_req.size() == 0) check("extra_req", 32'(bus.mem_read_en), 0);
      else check("req_addr", 32'(bus.memory_address), 32'(exp_req.pop_front()));
      pend.push_back('{cyc + lat, 16'hA000 + 16'(req_k)});
      req_k++;
    end
    if (bus.write_data_array) begin
      if (exp_wr.size() == 0) check("extra_write", 32'(bus.write_data_array), 0);
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(bus.cache_address), 32'(e.addr));
        check("wr_data", 32'(bus.cache_data), 32'(e.data));
        check("wr_tag",  32'(bus.write_tag_array), 32'(e.last));
        wr_in_fill++;
        if (e.last) begin
          next_fill = 1'b0;
          fills_done++;
          last_seen = 1'b1;
        end
      end
    end else begin
      check("tag_no_data", 32'(bus.write_tag_array), 0);
    end
    if (bus.write_tag_array) tag_seen++;
    if (bus.fsm_busy) busy_len++;
    else if (prev_busy) begin
      check("busy_len", busy_len, 8 + lat);
      busy_len = 0;
    end
    prev_busy = bus.fsm_busy;
    if (!model_fill && miss_v) begin
      for (int k = 0; k < 8; k++) begin
        exp_req.push_back((miss_a & 16'hFFF0) + 16'(2 * k));
        exp_wr.push_back('{(miss_a & 16'hFFF0) + 16'(2 * k), 16'hA000 + 16'(k), k == 7});
      end
      req_k      = 0;
      wr_in_fill = 0;
      next_fill  = 1'b1;
    end
    model_fill = next_fill;
  endtask

  task automatic wait_last(input int max_cyc);
    int i;
    last_seen = 1'b0;
    i = 0;
    while (!last_seen && i < max_cyc) begin
      step();
      i++;
    end
    check("wait_last_timeout", 32'(last_seen), 1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((pend.size() > 0 || model_fill) && i < 60) begin
      step();
      i++;
    end
    check("drain_timeout", 32'(pend.size()), 0);
    repeat (2) step();
  endtask

  task automatic start_miss(input logic [15:0] a);
    miss_v = 1'b1;
    miss_a = a;
    step();
    miss_v = 1'b0;
  endtask

  initial begin
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'h0;

    step();
    step();
    rst_v = 1'b0;
    step();

    // basic fill, then a ninth valid right after the last word
    start_miss(16'h1236);
    wait_last(40);
    stray_v = 1'b1;
    step();
    stray_v = 1'b0;
    drain();

    // stray valid in IDLE
    stray_v = 1'b1;
    repeat (2) step();
    stray_v = 1'b0;
    drain();

    // back-to-back: second miss in the cycle busy falls
    start_miss(16'h8888);
    wait_last(40);
    start_miss(16'hFFF2);
    wait_last(40);
    drain();

    // protocol-error valid in first FILL cycle, and a miss mid-fill
    start_miss(16'h2220);
    stray_v = 1'b1;
    step();
    stray_v = 1'b0;
    repeat (3) step();
    start_miss(16'h4000);
    wait_last(40);
    drain();

    // reset after three words
    start_miss(16'h5550);
    for (int i = 0; i < 40 && wr_in_fill < 3; i++) step();
    check("rst_wait_three", wr_in_fill, 3);
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    drain();
    start_miss(16'h6660);
    wait_last(40);
    drain();

    // latency variation
    lat = 1;
    start_miss(16'h7772);
    wait_last(40);
    drain();
    lat = 7;
    start_miss(16'h9998);
    wait_last(40);
    drain();

    check("tag_count", tag_seen, fills_done);
    check("fills_done", fills_done, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
